// File: rtl/scc_mem_dump.sv
// Post-halt memory dump: on a rising edge of halt_f, reads every word from START_ADDR
// to END_ADDR and streams each one out as an (address, data, last) record over valid/ready.
module scc_mem_dump #(
  parameter int unsigned           ADDR_W     = 16,
  parameter logic [ADDR_W-1:0]     START_ADDR = 16'h0000,
  parameter logic [ADDR_W-1:0]     END_ADDR   = 16'hFFFC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              halt_f,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              rec_valid,
  input  logic              rec_ready,
  output logic [ADDR_W-1:0] rec_addr,
  output logic [31:0]       rec_data,
  output logic              rec_last,
  output logic              dump_busy,
  output logic              dump_done
);

  typedef enum logic [2:0] {IDLE, READ, CAPTURE, OUT, DONE} state_t;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  state_t            r_state;
  state_t            w_next_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic              r_halt_prev;
  logic              r_mem_rd_en;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_rec_valid;
  logic [ADDR_W-1:0] r_rec_addr;
  logic [31:0]       r_rec_data;
  logic              r_rec_last;
  logic              r_dump_busy;
  logic              r_dump_done;

  logic              w_halt_rise;
  logic              w_is_last;
  logic [ADDR_W-1:0] w_next_addr;

  assign w_halt_rise = halt_f & ~r_halt_prev;
  assign w_is_last   = (r_cur_addr == END_ADDR);
  assign w_next_addr = r_cur_addr + ADDR_STEP;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else if (clk_en) begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_halt_rise) w_next_state = READ;
      READ:    w_next_state = CAPTURE;
      CAPTURE: w_next_state = OUT;
      OUT:     if (rec_ready) w_next_state = w_is_last ? DONE : READ;
      DONE:    w_next_state = DONE;
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are registered and set up one edge ahead, so mem_rd_en is already high
  // for the whole READ state and the record fields are valid for the whole OUT state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cur_addr  <= START_ADDR;
      r_halt_prev <= 1'b0;
      r_mem_rd_en <= 1'b0;
      r_mem_addr  <= '0;
      r_rec_valid <= 1'b0;
      r_rec_addr  <= '0;
      r_rec_data  <= '0;
      r_rec_last  <= 1'b0;
      r_dump_busy <= 1'b0;
      r_dump_done <= 1'b0;
    end else if (clk_en) begin
      r_halt_prev <= halt_f;
      case (r_state)
        IDLE: begin
          if (w_halt_rise) begin
            r_cur_addr  <= START_ADDR;
            r_dump_busy <= 1'b1;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= START_ADDR;
          end
        end
        READ: begin
          r_mem_rd_en <= 1'b0;
        end
        CAPTURE: begin
          r_rec_data  <= mem_rdata;
          r_rec_addr  <= r_cur_addr;
          r_rec_valid <= 1'b1;
          r_rec_last  <= w_is_last;
        end
        OUT: begin
          if (rec_ready) begin
            r_rec_valid <= 1'b0;
            r_rec_last  <= 1'b0;
            if (w_is_last) begin
              r_dump_busy <= 1'b0;
              r_dump_done <= 1'b1;
            end else begin
              // Termination relies on the equality compare, so a top-of-memory END_ADDR never wraps.
              r_cur_addr  <= w_next_addr;
              r_mem_rd_en <= 1'b1;
              r_mem_addr  <= w_next_addr;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem_rd_en = r_mem_rd_en;
  assign mem_addr  = r_mem_addr;
  assign rec_valid = r_rec_valid;
  assign rec_addr  = r_rec_addr;
  assign rec_data  = r_rec_data;
  assign rec_last  = r_rec_last;
  assign dump_busy = r_dump_busy;
  assign dump_done = r_dump_done;

endmodule

// File: tb/tb_scc_mem_dump.sv
// Bench for scc_mem_dump: three instances (small window, single word, top-of-memory window)
// share one memory model; expected records go into a queue and are popped at each handshake.
module tb_scc_mem_dump;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        last;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        rec_ready;
  logic [2:0]  haltF;

  logic [2:0]  memRdEn;
  logic [15:0] memAddr [3];
  logic [31:0] memRdata [3];
  logic [2:0]  recValid;
  logic [15:0] recAddr [3];
  logic [31:0] recData [3];
  logic [2:0]  recLast;
  logic [2:0]  dumpBusy;
  logic [2:0]  dumpDone;

  logic [31:0] mem [0:16383];
  rec_t        expQ [$];
  int          sel;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  scc_mem_dump #(.ADDR_W(16), .START_ADDR(16'h0880), .END_ADDR(16'h0894)) dutA (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(haltF[0]),
    .mem_rd_en(memRdEn[0]), .mem_addr(memAddr[0]), .mem_rdata(memRdata[0]),
    .rec_valid(recValid[0]), .rec_ready(rec_ready), .rec_addr(recAddr[0]),
    .rec_data(recData[0]), .rec_last(recLast[0]),
    .dump_busy(dumpBusy[0]), .dump_done(dumpDone[0]));

  scc_mem_dump #(.ADDR_W(16), .START_ADDR(16'h0100), .END_ADDR(16'h0100)) dutB (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(haltF[1]),
    .mem_rd_en(memRdEn[1]), .mem_addr(memAddr[1]), .mem_rdata(memRdata[1]),
    .rec_valid(recValid[1]), .rec_ready(rec_ready), .rec_addr(recAddr[1]),
    .rec_data(recData[1]), .rec_last(recLast[1]),
    .dump_busy(dumpBusy[1]), .dump_done(dumpDone[1]));

  scc_mem_dump #(.ADDR_W(16), .START_ADDR(16'hFF00), .END_ADDR(16'hFFFC)) dutC (
    .clk(clk), .rst(rst), .clk_en(clk_en), .halt_f(haltF[2]),
    .mem_rd_en(memRdEn[2]), .mem_addr(memAddr[2]), .mem_rdata(memRdata[2]),
    .rec_valid(recValid[2]), .rec_ready(rec_ready), .rec_addr(recAddr[2]),
    .rec_data(recData[2]), .rec_last(recLast[2]),
    .dump_busy(dumpBusy[2]), .dump_done(dumpDone[2]));

  // Synchronous-read memory: data appears on the enabled edge after the one that saw the strobe.
  always @(posedge clk) begin
    if (clk_en) begin
      for (int i = 0; i < 3; i++) begin
        if (memRdEn[i]) memRdata[i] <= mem[memAddr[i][15:2]];
      end
    end
  end

  task automatic push_expected_a();
    expQ.push_back('{16'h0880, 32'h00000010, 1'b0});
    expQ.push_back('{16'h0884, 32'h00000010, 1'b0});
    expQ.push_back('{16'h0888, 32'h00100010, 1'b0});
    expQ.push_back('{16'h088C, 32'h0F0F0F0F, 1'b0});
    expQ.push_back('{16'h0890, 32'h00000100, 1'b0});
    expQ.push_back('{16'h0894, 32'h00000100, 1'b1});
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Scoreboard consumer for instance sel: pops an expected record at every handshake and
  // checks read addresses, stall stability and the final busy/done state.
  task automatic run_scoreboard(input string tag, input int budget, input bit stall);
    rec_t expRec;
    rec_t held;
    bit   holding = 1'b0;
    int   cycles = 0;
    int   reads = 0;
    int   nExp;
    nExp = expQ.size();
    while (expQ.size() > 0 && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (holding) begin
        checks++;
        if (recValid[sel] !== 1'b1 || {recAddr[sel], recData[sel], recLast[sel]} !== held) begin
          errors++;
          $display("[TB] FAIL %s stall_hold: got v=%b %h/%h/%b required v=1 %h/%h/%b", tag,
                   recValid[sel], recAddr[sel], recData[sel], recLast[sel], held.addr, held.data, held.last);
        end
      end
      clk_en    = stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
      rec_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (memRdEn[sel] && clk_en) begin
        reads++;
        checks++;
        if (memAddr[sel] !== expQ[0].addr) begin
          errors++;
          $display("[TB] FAIL %s read_addr: got %h required %h", tag, memAddr[sel], expQ[0].addr);
        end
      end
      holding = 1'b0;
      if (recValid[sel] && clk_en && rec_ready) begin
        expRec = expQ.pop_front();
        checks++;
        if (recAddr[sel] !== expRec.addr || recData[sel] !== expRec.data || recLast[sel] !== expRec.last) begin
          errors++;
          $display("[TB] FAIL %s record: got %h/%h/%b required %h/%h/%b", tag,
                   recAddr[sel], recData[sel], recLast[sel], expRec.addr, expRec.data, expRec.last);
        end
      end else if (recValid[sel]) begin
        holding = 1'b1;
        held    = '{recAddr[sel], recData[sel], recLast[sel]};
      end
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s timeout: got %0d records left required 0", tag, expQ.size());
      expQ.delete();
    end
    @(negedge clk);
    clk_en    = 1'b1;
    rec_ready = 1'b1;
    checks++;
    if (dumpDone[sel] !== 1'b1 || dumpBusy[sel] !== 1'b0 || reads != nExp) begin
      errors++;
      $display("[TB] FAIL %s completion: got done=%b busy=%b reads=%0d required done=1 busy=0 reads=%0d",
               tag, dumpDone[sel], dumpBusy[sel], reads, nExp);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({memRdEn[i], memAddr[i], recValid[i], recAddr[i], recData[i], recLast[i], dumpBusy[i], dumpDone[i]} !== 69'd0) begin
        errors++;
        $display("[TB] FAIL reset_outputs[%0d]: got rd=%b ma=%h v=%b ra=%h rd=%h l=%b busy=%b done=%b required all 0", i,
                 memRdEn[i], memAddr[i], recValid[i], recAddr[i], recData[i], recLast[i], dumpBusy[i], dumpDone[i]);
      end
    end
    rst = 1'b1;
  endtask

  task automatic test_stream();
    sel = 0;
    haltF[0] = 1'b1;
    push_expected_a();
    run_scoreboard("stream", 60, 1'b0);
  endtask

  task automatic test_halt_after_done();
    int activity = 0;
    haltF[0] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (memRdEn[0] || recValid[0]) activity++;
    end
    haltF[0] = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (memRdEn[0] || recValid[0]) activity++;
    end
    checks++;
    if (activity != 0 || dumpDone[0] !== 1'b1 || dumpBusy[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL halt_after_done: got activity=%0d done=%b busy=%b required 0/1/0",
               activity, dumpDone[0], dumpBusy[0]);
    end
  endtask

  task automatic test_random_stall();
    sel = 0;
    pulse_reset();
    push_expected_a();
    run_scoreboard("random_stall", 400, 1'b1);
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    sel = 0;
    pulse_reset();
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (recValid[0] && recAddr[0] == 16'h0888) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL reset_mid_reach: got third record=0 required 1");
    end
    rst = 1'b0;
    #1;
    repeat (2) begin
      checks++;
      if ({memRdEn[0], memAddr[0], recValid[0], recAddr[0], recData[0], recLast[0], dumpBusy[0], dumpDone[0]} !== 69'd0) begin
        errors++;
        $display("[TB] FAIL reset_mid_outputs: got rd=%b ma=%h v=%b ra=%h rd=%h l=%b busy=%b done=%b required all 0",
                 memRdEn[0], memAddr[0], recValid[0], recAddr[0], recData[0], recLast[0], dumpBusy[0], dumpDone[0]);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    push_expected_a();
    run_scoreboard("reset_restart", 60, 1'b0);
  endtask

  task automatic test_single_word();
    sel = 1;
    haltF[1] = 1'b1;
    expQ.push_back('{16'h0100, 32'h00000040, 1'b1});
    run_scoreboard("single_word", 20, 1'b0);
  endtask

  task automatic test_top_end();
    int activity = 0;
    sel = 2;
    haltF[2] = 1'b1;
    for (int a = 16'hFF00; a <= 16'hFFFC; a += 4) begin
      expQ.push_back('{16'(a), 32'(a >> 2), (a == 16'hFFFC)});
    end
    run_scoreboard("top_end", 300, 1'b0);
    repeat (10) begin
      @(negedge clk);
      if (memRdEn[2] || recValid[2]) activity++;
    end
    checks++;
    if (activity != 0) begin
      errors++;
      $display("[TB] FAIL top_end_no_wrap: got activity=%0d required 0", activity);
    end
  endtask

  initial begin
    rst       = 1'b0;
    clk_en    = 1'b1;
    rec_ready = 1'b0;
    haltF     = 3'b000;
    sel       = 0;
    for (int k = 0; k < 16384; k++) mem[k] = 32'(k);
    mem[16'h0220] = 32'h00000010;
    mem[16'h0221] = 32'h00000010;
    mem[16'h0222] = 32'h00100010;
    mem[16'h0223] = 32'h0F0F0F0F;
    mem[16'h0224] = 32'h00000100;
    mem[16'h0225] = 32'h00000100;

    test_reset();
    test_stream();
    test_halt_after_done();
    test_random_stall();
    test_reset_mid();
    test_single_word();
    test_top_end();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scc_mem_dump.md
SCC_MEM_DUMP -- requirements
Module: scc_mem_dump

Interface
REQ-001 Parameter ADDR_W, default 16, byte-address width of the data memory.
REQ-002 Parameter START_ADDR, default 16'h0000, first byte address dumped; SHALL be word-aligned.
REQ-003 Parameter END_ADDR, default 16'hFFFC, last byte address dumped, inclusive; SHALL be word-aligned and at least START_ADDR.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 clk_en  in  1  global advance enable; registers update only on edges where clk_en=1.
REQ-007 halt_f  in  1  core halt flag; its rising edge starts a dump.
REQ-008 mem_rd_en  out  1  data-memory read strobe.
REQ-009 mem_addr  out  ADDR_W  data-memory byte address.
REQ-010 mem_rdata  in  32  read data, valid on the first clk_en edge after the edge that sampled mem_rd_en=1.
REQ-011 rec_valid  out  1  record-output valid.
REQ-012 rec_ready  in  1  record-output ready from the downstream sink.
REQ-013 rec_addr  out  ADDR_W  byte address of the current record.
REQ-014 rec_data  out  32  memory word of the current record.
REQ-015 rec_last  out  1  high with rec_valid on the record at END_ADDR only.
REQ-016 dump_busy  out  1  high from dump start until the final handshake.
REQ-017 dump_done  out  1  sticky completion flag.

Function
REQ-018 The block SHALL be a registered FSM with states IDLE, READ, CAPTURE, OUT and DONE; all outputs SHALL be registered.
REQ-019 Halt-edge detection: a register holding the previous halt_f SHALL reset to 0, so halt_f already high at the first enabled edge after reset counts as a rising edge.
REQ-020 IDLE -> READ on a detected rising edge of halt_f: cur_addr<=START_ADDR, dump_busy<=1.
REQ-021 READ: mem_rd_en=1 and mem_addr=cur_addr for exactly one enabled cycle, then go to CAPTURE.
REQ-022 CAPTURE: mem_rd_en=0; rec_data<=mem_rdata; rec_addr<=cur_addr; rec_valid<=1; rec_last<=(cur_addr==END_ADDR); then go to OUT.
REQ-023 OUT: rec_valid, rec_addr, rec_data and rec_last SHALL hold stable until an enabled edge with rec_ready=1.
REQ-024 On the OUT handshake: rec_valid<=0; if cur_addr==END_ADDR, go to DONE with dump_busy<=0 and dump_done<=1; else cur_addr<=cur_addr+4 and go to READ.
REQ-025 Throughput: at most one record per 3 enabled cycles; records SHALL be emitted in strictly ascending address order with none skipped or repeated; count = (END_ADDR-START_ADDR)/4+1.
REQ-026 DONE is terminal until reset; halt_f edges in DONE SHALL be ignored.
REQ-027 halt_f falling or re-rising during a dump SHALL be ignored; the dump completes.
REQ-028 rec_ready=1 while rec_valid=0 SHALL have no effect.
REQ-029 clk_en=0 SHALL freeze all state and outputs; a handshake SHALL count only on an edge with clk_en=1.
REQ-030 START_ADDR==END_ADDR SHALL yield exactly one record, with rec_last=1.
REQ-031 cur_addr arithmetic is ADDR_W wide; END_ADDR=2^ADDR_W-4 SHALL terminate by the equality compare without any wrap-around record.

Reset
REQ-032 rst=0 SHALL immediately force: state=IDLE, cur_addr=START_ADDR, halt-edge register=0, mem_rd_en=0, mem_addr=0, rec_valid=0, rec_addr=0, rec_data=0, rec_last=0, dump_busy=0, dump_done=0.
REQ-033 Reset asserted mid-dump SHALL abort the dump with no further records; after release, a new dump requires a detected halt_f rising edge, which includes halt_f still being high.

Verification
REQ-034 Memory preloaded with word k at byte address 4k, halt_f raised, rec_ready=1 -> 16384 records; the record at 0x0880 has data 0x00000220 and rec_last=0; the record at 0xFFFC has data 0x00003FFF and rec_last=1; then dump_done=1 and dump_busy=0.
REQ-035 START_ADDR=0x0880, END_ADDR=0x0894, memory 0x0880..0x0894 = 0x10, 0x10, 0x00100010, 0x0F0F0F0F, 0x100, 0x100 -> exactly these 6 records in order; rec_last only on 0x0894.
REQ-036 rec_ready toggled pseudo-randomly and clk_en low 30% of cycles -> identical record stream to REQ-035; rec_addr and rec_data are stable during every stall.
REQ-037 rst pulsed low during the 3rd record with halt_f held high -> all outputs read 0 during reset; after release, the dump restarts at START_ADDR and completes normally.
REQ-038 Second halt_f pulse after dump_done -> no records and no mem_rd_en; START_ADDR==END_ADDR=0x0100 -> one record with rec_last=1.
